// File: rtl/bdl_dma_seq.sv
// DELQA BDL DMA sequencer: descriptor fetch/chain and status write-back.
// Optional BDL_DMA_TIMEOUT_EN adds a DMA grant/ack timeout (err 01).
module bdl_dma_seq #(
    parameter logic [15:0] FLAG_INUSE = 16'hC000,
    parameter int          MAX_CHAIN  = 4,
    parameter int          TMO_W      = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        fetch_i,
    input  logic        wrbk_i,
    input  logic [21:0] base_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        valid_o,
    output logic [1:0]  err_o,
    output logic        dma_req_o,
    input  logic        dma_gnt_i,
    output logic [21:0] dma_adr_o,
    output logic [15:0] dma_dat_o,
    input  logic [15:0] dma_dat_i,
    output logic        dma_we_o,
    output logic        dma_stb_o,
    input  logic        dma_ack_i,
    output logic [2:0]  bdl_adr_o,
    output logic [15:0] bdl_dat_o,
    output logic        bdl_we_o,
    output logic        bdl_stb_o,
    input  logic [15:0] bdl_dat_i
);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_FLAG, S_RD, S_BWR, S_CHK,
        S_WBRD, S_WBSMP, S_WBWR, S_REL
    } state_t;

    localparam logic [7:0] MAXC = 8'(MAX_CHAIN);

    state_t      state_q, state_d;
    logic [21:0] base_q, base_d;
    logic [2:0]  n_q, n_d;
    logic [15:0] dat_q, dat_d;
    logic [7:0]  w1_q, w1_d;
    logic [14:0] w2_q, w2_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fetch_q, fetch_d;
    logic        valid_q, valid_d;
    logic [1:0]  err_q, err_d;
    logic [21:0] haddr;
    logic        stb_st;
    logic        tmo_hit;
    logic        unused_base;

    assign unused_base = base_i[0];
    assign haddr   = base_q + {18'd0, n_q, 1'b0};
    assign stb_st  = (state_q == S_FLAG) || (state_q == S_RD) ||
                     (state_q == S_WBWR);
    assign busy_o  = (state_q != S_IDLE);
    assign valid_o = valid_q;
    assign err_o   = err_q;

`ifdef BDL_DMA_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             waiting;

    // Counter restarts whenever a strobe completes or the state moves on.
    always_comb begin
        waiting = ((state_q == S_REQ) && !dma_gnt_i) ||
                  (stb_st && !dma_ack_i);
        tmo_d   = waiting ? tmo_q + 1'b1 : '0;
        tmo_hit = waiting && (tmo_q == TMO_LAST);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) tmo_q <= '0;
        else           tmo_q <= tmo_d;
    end
`else
    logic [TMO_W-1:0] unused_tmo;
    assign unused_tmo = '0;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        n_d       = n_q;
        dat_d     = dat_q;
        w1_d      = w1_q;
        w2_d      = w2_q;
        cnt_d     = cnt_q;
        fetch_d   = fetch_q;
        valid_d   = valid_q;
        err_d     = err_q;
        done_o    = 1'b0;
        dma_req_o = 1'b0;
        dma_adr_o = '0;
        dma_dat_o = '0;
        dma_we_o  = 1'b0;
        dma_stb_o = 1'b0;
        bdl_adr_o = '0;
        bdl_dat_o = '0;
        bdl_we_o  = 1'b0;
        bdl_stb_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fetch_i || wrbk_i) begin
                    base_d  = {base_i[21:1], 1'b0};
                    fetch_d = fetch_i;
                    err_d   = 2'b00;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                dma_req_o = 1'b1;
                if (dma_gnt_i) begin
                    n_d     = fetch_q ? 3'd0 : 3'd4;
                    state_d = fetch_q ? S_FLAG : S_WBRD;
                end
            end
            S_FLAG: begin
                dma_req_o = 1'b1;
                dma_stb_o = 1'b1;
                dma_we_o  = 1'b1;
                dma_adr_o = haddr;
                dma_dat_o = FLAG_INUSE;
                if (dma_ack_i) begin
                    n_d     = 3'd1;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                dma_req_o = 1'b1;
                dma_stb_o = 1'b1;
                dma_adr_o = haddr;
                if (dma_ack_i) begin
                    dat_d = dma_dat_i;
                    if (n_q == 3'd1)
                        w1_d = {dma_dat_i[15:14], dma_dat_i[5:0]};
                    if (n_q == 3'd2)
                        w2_d = dma_dat_i[15:1];
                    state_d = S_BWR;
                end
            end
            S_BWR: begin
                dma_req_o = 1'b1;
                bdl_stb_o = 1'b1;
                bdl_we_o  = 1'b1;
                bdl_adr_o = n_q;
                bdl_dat_o = dat_q;
                if (n_q == 3'd3) begin
                    state_d = S_CHK;
                end else begin
                    n_d     = n_q + 3'd1;
                    state_d = S_RD;
                end
            end
            S_CHK: begin
                dma_req_o = 1'b1;
                valid_d   = w1_q[7];
                if (w1_q[7] && w1_q[6]) begin
                    base_d = {w1_q[5:0], w2_q, 1'b0};
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == MAXC) begin
                        err_d   = 2'b10;
                        state_d = S_REL;
                    end else begin
                        n_d     = 3'd0;
                        state_d = S_FLAG;
                    end
                end else begin
                    state_d = S_REL;
                end
            end
            S_WBRD: begin
                dma_req_o = 1'b1;
                bdl_stb_o = 1'b1;
                bdl_adr_o = n_q;
                state_d   = S_WBSMP;
            end
            S_WBSMP: begin
                dma_req_o = 1'b1;
                dat_d     = bdl_dat_i;
                state_d   = S_WBWR;
            end
            S_WBWR: begin
                dma_req_o = 1'b1;
                dma_stb_o = 1'b1;
                dma_we_o  = 1'b1;
                dma_adr_o = haddr;
                dma_dat_o = dat_q;
                if (dma_ack_i) begin
                    if (n_q == 3'd4) begin
                        n_d     = 3'd5;
                        state_d = S_WBRD;
                    end else if (n_q == 3'd5) begin
                        // Final write releases the host flag word.
                        n_d   = 3'd0;
                        dat_d = 16'h0000;
                    end else begin
                        state_d = S_REL;
                    end
                end
            end
            S_REL: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (tmo_hit) begin
            err_d   = 2'b01;
            state_d = S_REL;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            n_q     <= '0;
            dat_q   <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            cnt_q   <= '0;
            fetch_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            n_q     <= n_d;
            dat_q   <= dat_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            cnt_q   <= cnt_d;
            fetch_q <= fetch_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_bdl_dma_seq.sv
// Scoreboard bench for bdl_dma_seq: host memory and BDL models,
// expected host writes / BDL writes / done events queued and popped by a monitor.
module tb_bdl_dma_seq;

    logic        clk = 1'b0;
    logic        wb_rst_n;
    logic        fetch_i, wrbk_i;
    logic [21:0] base_i;
    logic        busy_o, done_o, valid_o;
    logic [1:0]  err_o;
    logic        dma_req_o, dma_gnt_i;
    logic [21:0] dma_adr_o;
    logic [15:0] dma_dat_o, dma_dat_i;
    logic        dma_we_o, dma_stb_o, dma_ack_i;
    logic [2:0]  bdl_adr_o;
    logic [15:0] bdl_dat_o, bdl_dat_i;
    logic        bdl_we_o, bdl_stb_o;

    always #5 clk = ~clk;

    bdl_dma_seq #(.TMO_W(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_n (wb_rst_n),
        .fetch_i  (fetch_i),
        .wrbk_i   (wrbk_i),
        .base_i   (base_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .valid_o  (valid_o),
        .err_o    (err_o),
        .dma_req_o(dma_req_o),
        .dma_gnt_i(dma_gnt_i),
        .dma_adr_o(dma_adr_o),
        .dma_dat_o(dma_dat_o),
        .dma_dat_i(dma_dat_i),
        .dma_we_o (dma_we_o),
        .dma_stb_o(dma_stb_o),
        .dma_ack_i(dma_ack_i),
        .bdl_adr_o(bdl_adr_o),
        .bdl_dat_o(bdl_dat_o),
        .bdl_we_o (bdl_we_o),
        .bdl_stb_o(bdl_stb_o),
        .bdl_dat_i(bdl_dat_i)
    );

    typedef struct {
        int          k;
        logic [21:0] a;
        logic [15:0] d;
    } ev_t;

    ev_t         exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] mem [logic [21:0]];
    logic [15:0] bdl_arr [0:7];
    logic        hold_ack = 1'b0;
    logic        stray    = 1'b0;
    int          stb_cnt  = 0;

    function automatic logic [15:0] rd(logic [21:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    task automatic push(int k, logic [21:0] a, logic [15:0] d);
        ev_t e;
        e.k = k; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    // k: 0 host write, 1 BDL write, 2 done (a=err, d=valid)
    task automatic push_fetch(logic [21:0] b, logic [15:0] w1,
                              logic [15:0] w2, logic [15:0] w3);
        push(0, b, 16'hC000);
        push(1, 22'd1, w1);
        push(1, 22'd2, w2);
        push(1, 22'd3, w3);
    endtask

    task automatic chk(string nm, logic [127:0] got, logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic observe(int k, logic [21:0] a, logic [15:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL ev_unexpected got k=%0d a=%h d=%h want none",
                     k, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.k != k || e.a !== a || e.d !== d) begin
                failures++;
                $display("FAIL ev got k=%0d a=%h d=%h want k=%0d a=%h d=%h",
                         k, a, d, e.k, e.a, e.d);
            end
        end
    endtask

    // Host Q-bus model: grant follows request; ack alternates so some
    // transfers complete at once and others after a wait cycle.
    always @(posedge clk) begin
        #1;
        dma_gnt_i = dma_req_o;
        if (dma_stb_o && !hold_ack && !dma_ack_i) begin
            dma_ack_i = 1'b1;
            dma_dat_i = dma_we_o ? 16'h0000 : rd(dma_adr_o);
        end else begin
            dma_ack_i = !dma_stb_o && stray;
            dma_dat_i = 16'h0000;
        end
    end

    // Monitor plus BDL register-file model.
    always @(negedge clk) begin
        if (wb_rst_n) begin
            if (dma_stb_o) stb_cnt++;
            if (dma_stb_o || bdl_stb_o)
                chk("stb_excl", {126'd0, dma_stb_o, bdl_stb_o},
                    {126'd0, dma_stb_o, !dma_stb_o});
            if (dma_stb_o && dma_ack_i && dma_we_o) begin
                mem[dma_adr_o] = dma_dat_o;
                observe(0, dma_adr_o, dma_dat_o);
            end
            if (bdl_stb_o && bdl_we_o) begin
                bdl_arr[bdl_adr_o] = bdl_dat_o;
                observe(1, {19'd0, bdl_adr_o}, bdl_dat_o);
            end
            if (bdl_stb_o && !bdl_we_o)
                bdl_dat_i = bdl_arr[bdl_adr_o];
            if (done_o)
                observe(2, {20'd0, err_o}, {15'd0, valid_o});
        end
    end

    task automatic cmd(logic f, logic w, logic [21:0] b);
        @(negedge clk);
        fetch_i = f;
        wrbk_i  = w;
        base_i  = b;
        @(negedge clk);
        fetch_i = 1'b0;
        wrbk_i  = 1'b0;
    endtask

    task automatic wait_idle(string nm, int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {127'd0, busy_o}, 128'd0);
        repeat (2) @(negedge clk);
        chk({nm, "_q"}, exp_q.size(), 0);
    endtask

    function automatic logic [127:0] all_out();
        return {61'd0, busy_o, done_o, valid_o, err_o, dma_req_o,
                dma_adr_o, dma_dat_o, dma_we_o, dma_stb_o,
                bdl_adr_o, bdl_dat_o, bdl_we_o, bdl_stb_o};
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        wb_rst_n  = 1'b0;
        fetch_i   = 1'b0;
        wrbk_i    = 1'b0;
        base_i    = '0;
        dma_gnt_i = 1'b0;
        dma_ack_i = 1'b0;
        dma_dat_i = '0;
        bdl_dat_i = '0;
        for (int i = 0; i < 8; i++) bdl_arr[i] = 16'h0;
        mem[22'h001002] = 16'h8005;
        mem[22'h001004] = 16'h2000;
        mem[22'h001006] = 16'hFE00;
        mem[22'h010002] = 16'hC003;
        mem[22'h010004] = 16'h4000;
        mem[22'h010006] = 16'h0040;
        mem[22'h034002] = 16'hC000;
        mem[22'h034004] = 16'h5000;
        mem[22'h034006] = 16'h0041;
        mem[22'h005002] = 16'hC001;
        mem[22'h005004] = 16'h8000;
        mem[22'h005006] = 16'h0042;
        mem[22'h018002] = 16'hC002;
        mem[22'h018004] = 16'h0100;
        mem[22'h018006] = 16'h0043;
        mem[22'h3FFFFE] = 16'h0000;
        mem[22'h000000] = 16'h1111;
        mem[22'h000002] = 16'h2222;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_out(), 128'd0);
        wb_rst_n = 1'b1;

        // stray ack while idle must not start anything
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        chk("stray_ack_idle", {127'd0, busy_o}, 128'd0);

        // basic fetch
        push_fetch(22'h001000, 16'h8005, 16'h2000, 16'hFE00);
        push(2, 22'd0, 16'd1);
        cmd(1'b1, 1'b0, 22'h001000);
        wait_idle("basic", 100);

        // chain limit
        push_fetch(22'h010000, 16'hC003, 16'h4000, 16'h0040);
        push_fetch(22'h034000, 16'hC000, 16'h5000, 16'h0041);
        push_fetch(22'h005000, 16'hC001, 16'h8000, 16'h0042);
        push_fetch(22'h018000, 16'hC002, 16'h0100, 16'h0043);
        push(2, 22'd2, 16'd1);
        cmd(1'b1, 1'b0, 22'h010000);
        wait_idle("chain", 300);
        chk("chain_req_low", {127'd0, dma_req_o}, 128'd0);
        chk("chain_err", {126'd0, err_o}, 128'd2);

        // address wrap, bit 0 ignored, valid clear
        push_fetch(22'h3FFFFC, 16'h0000, 16'h1111, 16'h2222);
        push(2, 22'd0, 16'd0);
        cmd(1'b1, 1'b0, 22'h3FFFFD);
        wait_idle("wrap", 100);
        chk("wrap_valid", {127'd0, valid_o}, 128'd0);

        // write-back
        bdl_arr[4] = 16'h1234;
        bdl_arr[5] = 16'hABCD;
        push(0, 22'h000208, 16'h1234);
        push(0, 22'h00020A, 16'hABCD);
        push(0, 22'h000200, 16'h0000);
        push(2, 22'd0, 16'd0);
        cmd(1'b0, 1'b1, 22'h000200);
        wait_idle("wrbk", 100);

        // simultaneous pulses -> fetch; pulses while busy ignored
        push_fetch(22'h001000, 16'h8005, 16'h2000, 16'hFE00);
        push(2, 22'd0, 16'd1);
        cmd(1'b1, 1'b1, 22'h001000);
        cmd(1'b0, 1'b1, 22'h000200);
        cmd(1'b1, 1'b0, 22'h005000);
        wait_idle("simul", 100);

        // ack withheld
        hold_ack = 1'b1;
        stb_cnt  = 0;
`ifdef BDL_DMA_TIMEOUT_EN
        push(2, 22'd1, 16'd1);
        cmd(1'b1, 1'b0, 22'h001000);
        wait_idle("tmo", 60);
        chk("tmo_stb_cycles", stb_cnt, 15);
        chk("tmo_err", {126'd0, err_o}, 128'd1);
`else
        cmd(1'b1, 1'b0, 22'h001000);
        repeat (40) @(negedge clk);
        chk("hang_busy", {127'd0, busy_o}, 128'd1);
        chk("hang_stb", {127'd0, dma_stb_o}, 128'd1);
`endif
        hold_ack = 1'b0;
        wb_rst_n = 1'b0;
        #1;
        chk("rst_recover_out", all_out(), 128'd0);
        repeat (2) @(negedge clk);
        wb_rst_n = 1'b1;

        // reset during RD(2)
        push(0, 22'h001000, 16'hC000);
        push(1, 22'd1, 16'h8005);
        cmd(1'b1, 1'b0, 22'h001000);
        n = 0;
        while (!(dma_stb_o && !dma_we_o && dma_adr_o == 22'h001004)
               && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rd2_reached", {127'd0, n < 50}, 128'd1);
        wb_rst_n = 1'b0;
        #1;
        chk("rst_mid_out", all_out(), 128'd0);
        chk("rst_mid_q", exp_q.size(), 0);
        @(negedge clk);
        wb_rst_n = 1'b1;

        push_fetch(22'h001000, 16'h8005, 16'h2000, 16'hFE00);
        push(2, 22'd0, 16'd1);
        cmd(1'b1, 1'b0, 22'h001000);
        wait_idle("after_rst", 100);

        chk("q_final", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
